multicycle_ctrl: RTL

Multi-cycle sequencing controller for the MIPS datapath: a Moore FSM that steps each instruction through fetch, decode, execute, memory and write-back over 3–5 cycles. It drives every datapath select and enable, handles branch resolution, jumps and the syscall halt/resume handshake, and keeps a retired-instruction counter. It replaces the per-instruction combinational control when the datapath shares one memory and one ALU across cycles.

---
 rtl/multicycle_pkg.sv | 95 +++++++++
 rtl/multicycle_ctrl_classify.sv | 37 +++
 rtl/multicycle_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multi-cycle MIPS sequencing controller.
package multicycle_pkg;

    // Controller states, 4-bit encoding (exactly 16 states)
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        WB_R     = 4'd4,
        WB_I     = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        MEM_WB   = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        JAL      = 4'd12,
        JR       = 4'd13,
        SYSCALL  = 4'd14,
        HALT     = 4'd15
    } state_t;

    // Instruction classes produced by instr_classify
    typedef enum logic [3:0] {
        C_RALU    = 4'd0,
        C_IALU    = 4'd1,
        C_LW      = 4'd2,
        C_SW      = 4'd3,
        C_BEQ     = 4'd4,
        C_BNE     = 4'd5,
        C_J       = 4'd6,
        C_JAL     = 4'd7,
        C_JR      = 4'd8,
        C_SYSCALL = 4'd9,
        C_ILLEGAL = 4'd10
    } iclass_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    // RegDst select
    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    // MemToReg select
    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    // AluSrcB select
    localparam logic [1:0] ALUB_REG     = 2'd0;
    localparam logic [1:0] ALUB_FOUR    = 2'd1;
    localparam logic [1:0] ALUB_IMM     = 2'd2;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

    // PCSrc select
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REG    = 2'd3;

    // Logical immediates (andi, ori) are zero-extended; everything else sign-extends
    function automatic logic is_zero_ext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_classify.sv
// Combinational opcode/funct decoder: maps the IR fields to an instruction class.
module instr_classify
    import multicycle_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_func,
    output iclass_t    o_class
);

    // Decode OP first, then Func for the R-type group
    always_comb begin
        o_class = C_ILLEGAL;
        case (i_op)
            OP_RTYPE: begin
                case (i_func)
                    FN_SLL, FN_SRL, FN_SRA,
                    FN_ADD, FN_ADDU, FN_SUB,
                    FN_AND, FN_OR, FN_NOR,
                    FN_SLT, FN_SLTU:        o_class = C_RALU;
                    FN_JR:                  o_class = C_JR;
                    FN_SYSCALL:             o_class = C_SYSCALL;
                    default:                o_class = C_ILLEGAL;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI,
            OP_ANDI, OP_ORI:                o_class = C_IALU;
            OP_LW:                          o_class = C_LW;
            OP_SW:                          o_class = C_SW;
            OP_BEQ:                         o_class = C_BEQ;
            OP_BNE:                         o_class = C_BNE;
            OP_J:                           o_class = C_J;
            OP_JAL:                         o_class = C_JAL;
            default:                        o_class = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencing controller: Moore FSM driving every datapath
// select/enable, plus a retired-instruction counter.
module multicycle_ctrl
    import multicycle_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  OP,
    input  logic [5:0]  Func,
    input  logic        Zero,
    input  logic        V0Is10,
    input  logic        Go,
    output logic        PCEn,
    output logic        IorD,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemToReg,
    output logic        AluSrcA,
    output logic [1:0]  AluSrcB,
    output logic        AluAdd,
    output logic        SignedExt,
    output logic [1:0]  PCSrc,
    output logic        SysCallShow,
    output logic        Halted,
    output logic        Retire,
    output logic        IllegalOp,
    output logic [31:0] InstrCount
);

    state_t      r_state;
    state_t      w_next;
    iclass_t     w_class;
    logic [31:0] r_instr_count;

    logic        w_pcen;
    logic        w_iord;
    logic        w_memwrite;
    logic        w_irwrite;
    logic        w_regwrite;
    logic [1:0]  w_regdst;
    logic [1:0]  w_memtoreg;
    logic        w_alusrca;
    logic [1:0]  w_alusrcb;
    logic        w_aluadd;
    logic        w_signedext;
    logic [1:0]  w_pcsrc;
    logic        w_syscallshow;
    logic        w_halted;
    logic        w_retire;
    logic        w_illegal;

    instr_classify u_classify (
        .i_op    (OP),
        .i_func  (Func),
        .o_class (w_class)
    );

    // State register; reset lands in FETCH so the first post-reset cycle fetches
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_count <= '0;
        end else if (w_retire) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

    // Next-state and per-state control outputs
    always_comb begin
        w_next        = FETCH;
        w_pcen        = 1'b0;
        w_iord        = 1'b0;
        w_memwrite    = 1'b0;
        w_irwrite     = 1'b0;
        w_regwrite    = 1'b0;
        w_regdst      = REGDST_RT;
        w_memtoreg    = M2R_ALUOUT;
        w_alusrca     = 1'b0;
        w_alusrcb     = ALUB_REG;
        w_aluadd      = 1'b0;
        w_signedext   = ~is_zero_ext(OP);
        w_pcsrc       = PCSRC_ALU;
        w_syscallshow = 1'b0;
        w_halted      = 1'b0;
        w_retire      = 1'b0;
        w_illegal     = 1'b0;

        unique case (r_state)
            FETCH: begin
                w_irwrite = 1'b1;
                w_alusrcb = ALUB_FOUR;
                w_aluadd  = 1'b1;
                w_pcsrc   = PCSRC_ALU;
                w_pcen    = 1'b1;
                w_next    = DECODE;
            end
            DECODE: begin
                // ALUOut captures PC+4 + (imm << 2) as the speculative branch target
                w_alusrcb = ALUB_IMM_SH2;
                w_aluadd  = 1'b1;
                unique case (w_class)
                    C_RALU:    w_next = EXEC_R;
                    C_IALU:    w_next = EXEC_I;
                    C_LW,
                    C_SW:      w_next = MEM_ADDR;
                    C_BEQ,
                    C_BNE:     w_next = BRANCH;
                    C_J:       w_next = JUMP;
                    C_JAL:     w_next = JAL;
                    C_JR:      w_next = JR;
                    C_SYSCALL: w_next = SYSCALL;
                    default: begin
                        w_next    = FETCH;
                        w_illegal = 1'b1;
                        w_retire  = 1'b1;
                    end
                endcase
            end
            EXEC_R: begin
                w_alusrca = 1'b1;
                w_alusrcb = ALUB_REG;
                w_next    = WB_R;
            end
            WB_R: begin
                w_regwrite = 1'b1;
                w_regdst   = REGDST_RD;
                w_memtoreg = M2R_ALUOUT;
                w_retire   = 1'b1;
            end
            EXEC_I: begin
                w_alusrca = 1'b1;
                w_alusrcb = ALUB_IMM;
                w_next    = WB_I;
            end
            WB_I: begin
                w_regwrite = 1'b1;
                w_regdst   = REGDST_RT;
                w_memtoreg = M2R_ALUOUT;
                w_retire   = 1'b1;
            end
            MEM_ADDR: begin
                w_alusrca = 1'b1;
                w_alusrcb = ALUB_IMM;
                w_aluadd  = 1'b1;
                w_next    = (OP == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                w_iord = 1'b1;
                w_next = MEM_WB;
            end
            MEM_WB: begin
                w_regwrite = 1'b1;
                w_regdst   = REGDST_RT;
                w_memtoreg = M2R_MDR;
                w_retire   = 1'b1;
            end
            MEM_WR: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
                w_retire   = 1'b1;
            end
            BRANCH: begin
                // The ALU compares A and B here; Zero then gates the PC load
                w_alusrca = 1'b1;
                w_alusrcb = ALUB_REG;
                w_pcsrc   = PCSRC_ALUOUT;
                w_pcen    = (OP == OP_BNE) ? ~Zero : Zero;
                w_retire  = 1'b1;
            end
            JUMP: begin
                w_pcsrc  = PCSRC_JUMP;
                w_pcen   = 1'b1;
                w_retire = 1'b1;
            end
            JAL: begin
                // PC already holds PC+4 from FETCH, which is the link value
                w_pcsrc    = PCSRC_JUMP;
                w_pcen     = 1'b1;
                w_regwrite = 1'b1;
                w_regdst   = REGDST_RA;
                w_memtoreg = M2R_PC;
                w_retire   = 1'b1;
            end
            JR: begin
                w_pcsrc  = PCSRC_REG;
                w_pcen   = 1'b1;
                w_retire = 1'b1;
            end
            SYSCALL: begin
                w_retire = 1'b1;
                if (V0Is10) begin
                    w_next = HALT;
                end else begin
                    w_syscallshow = 1'b1;
                    w_next        = FETCH;
                end
            end
            HALT: begin
                w_halted = 1'b1;
                w_next   = Go ? FETCH : HALT;
            end
            default: begin
                w_next = FETCH;
            end
        endcase
    end

    // Reset forces every output low regardless of the current state
    assign PCEn        = w_pcen        & ~rst;
    assign IorD        = w_iord        & ~rst;
    assign MemWrite    = w_memwrite    & ~rst;
    assign IRWrite     = w_irwrite     & ~rst;
    assign RegWrite    = w_regwrite    & ~rst;
    assign RegDst      = rst ? '0 : w_regdst;
    assign MemToReg    = rst ? '0 : w_memtoreg;
    assign AluSrcA     = w_alusrca     & ~rst;
    assign AluSrcB     = rst ? '0 : w_alusrcb;
    assign AluAdd      = w_aluadd      & ~rst;
    assign SignedExt   = w_signedext   & ~rst;
    assign PCSrc       = rst ? '0 : w_pcsrc;
    assign SysCallShow = w_syscallshow & ~rst;
    assign Halted      = w_halted      & ~rst;
    assign Retire      = w_retire      & ~rst;
    assign IllegalOp   = w_illegal     & ~rst;
    assign InstrCount  = rst ? '0 : r_instr_count;

endmodule
